counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
Parameterised, prescaled up/down counter. It replaces the fixed 8-bit free-running testbench counter with a reusable block that has a programmable modulo limit, a wrap or saturate mode, a synchronous load and clear, a terminal-count pulse and a sticky overflow flag. It is instantiated in testbenches and DUT wrappers wherever a VPI-observable event counter or timebase is needed.

Parameters:
WIDTH, 8, counter width in bits (>=2)
PRESCALE_W, 4, width of the prescale divider register (>=1)
RESET_VALUE, 0, value of count after reset and after clear (must be <= 2^WIDTH-1)
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  count enable; the prescaler advances only while en=1
clear  in  1  synchronous clear to RESET_VALUE
load  in  1  synchronous load of load_value
load_value  in  WIDTH  value to load
dir  in  1  1 = count up, 0 = count down
max_value  in  WIDTH  inclusive upper bound (modulo limit)
prescale  in  PRESCALE_W  step every prescale+1 enabled cycles
ovf_clr  in  1  clears ovf_sticky
count  out  WIDTH  current count
tc  out  1  one-cycle terminal-count pulse
ovf_sticky  out  1  set on any tc; held until ovf_clr

Behaviour:
- Reset (async, active-high): count=RESET_VALUE, div=0, tc=0, ovf_sticky=0. Outputs stay in this state while reset is high.
- All other updates happen on the rising clk edge. Priority: clear > load > step.
- clear: count=RESET_VALUE, div=0, tc=0. Ignores en.
- load: count=load_value, div=0, tc=0. Ignores en. load_value > max_value is accepted as is.
- Prescaler:
  - With en=1 and no clear/load: if div==prescale then a step occurs and div=0; otherwise div=div+1.
  - en=0 holds div and count, and tc=0.
  - prescale=0 gives a step on every enabled cycle.
  - Changing prescale mid-count takes effect on the next compare.
  - If div > prescale after a change, div is treated as a match: step and div=0.
- Step, up (dir=1):
  - If count >= max_value: the bound is hit. SATURATE=0 gives count=0; SATURATE=1 gives count=max_value.
  - Otherwise count=count+1.
- Step, down (dir=0):
  - If count==0: the bound is hit. SATURATE=0 gives count=max_value; SATURATE=1 holds count=0.
  - If count > max_value: count=max_value.
  - Otherwise count=count-1.
- Bound hit:
  - tc=1 for exactly the cycle following the step edge, coincident with the new count value.
  - In saturate mode tc pulses on every step attempted at the bound.
  - tc=0 in all other cycles.
- max_value=0: every step is a bound hit; count stays at 0 and tc pulses on each step.
- All arithmetic is modulo 2^WIDTH, with no intermediate width growth visible at count. max_value=2^WIDTH-1 gives natural binary wrap.
- ovf_sticky:
  - Set on the same edge that sets tc.
  - Cleared by ovf_clr=1.
  - If the set and ovf_clr occur on the same edge, set wins.
  - clear and load do not affect it; only reset and ovf_clr do.
- dir may change on any cycle; the next step uses the value sampled at that step edge.
- Reset asserted mid-count forces the reset state immediately, with no clock needed. After deassertion the first step requires prescale+1 enabled cycles.

Test Plan:
- Reset, then en=1, dir=1, prescale=0, max_value=255, 300 cycles -> count goes 0..255, then 0 at cycle 256; tc high for one cycle exactly there; ovf_sticky=1 afterwards.
- prescale=3, max_value=9, dir=1, en=1 -> count increments every 4th cycle; after 40 cycles count=0 with one tc pulse; en low for 5 cycles mid-run freezes both count and div.
- SATURATE=1, dir=0, load_value=2 -> count 2,1,0,0,0; tc pulses on each step at 0 (two pulses in five steps); dir=1 then climbs normally.
- clear, load and step in the same cycle -> count=RESET_VALUE, tc=0. Load only, with load_value=200 and max_value=50, dir=1 -> next step wraps to 0 with tc. With dir=0 instead -> count=50, no tc.
- ovf_clr on the same edge as a tc event -> ovf_sticky stays 1. ovf_clr alone on the next cycle -> ovf_sticky=0.
- Async reset asserted between clock edges with count=7 and div=2 -> count=RESET_VALUE and tc=0 before the next edge. After release, with prescale=2, the first step lands on the 3rd enabled edge.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: prescaled up/down event counter with a programmable
// inclusive upper bound, wrap or saturate behaviour at the bounds,
// synchronous clear/load, a one-cycle terminal-count pulse and a sticky
// overflow flag. Every output comes straight from a flop.

module counter_ctrl #(
   parameter int               WIDTH       = 8,
   parameter int               PRESCALE_W  = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter bit               SATURATE    = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic                  dir,
   input  logic [WIDTH-1:0]      max_value,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  ovf_clr,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  ovf_sticky
);

   // Result of one counting step: the new count and whether a bound was hit.
   typedef struct packed {
      logic             hit;
      logic [WIDTH-1:0] value;
   } step_t;

   localparam logic [WIDTH-1:0]      CNT_ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]      CNT_ONE_C  = WIDTH'(1'b1);
   localparam logic [PRESCALE_W-1:0] DIV_ZERO_C = {PRESCALE_W{1'b0}};
   localparam logic [PRESCALE_W-1:0] DIV_ONE_C  = PRESCALE_W'(1'b1);

   // Upward step. Any count at or above the limit (including a value that
   // was loaded above it) counts as hitting the bound.
   function automatic step_t step_up(input logic [WIDTH-1:0] cur,
                                     input logic [WIDTH-1:0] lim);
      step_t r;
      if (cur >= lim) begin
         r.hit   = 1'b1;
         r.value = SATURATE ? lim : CNT_ZERO_C;
      end else begin
         r.hit   = 1'b0;
         r.value = cur + CNT_ONE_C;
      end
      return r;
   endfunction

   // Downward step. Zero is the bound; a count left above the limit is
   // pulled back to the limit without signalling a bound hit.
   function automatic step_t step_down(input logic [WIDTH-1:0] cur,
                                       input logic [WIDTH-1:0] lim);
      step_t r;
      if (cur == CNT_ZERO_C) begin
         r.hit   = 1'b1;
         r.value = SATURATE ? CNT_ZERO_C : lim;
      end else if (cur > lim) begin
         r.hit   = 1'b0;
         r.value = lim;
      end else begin
         r.hit   = 1'b0;
         r.value = cur - CNT_ONE_C;
      end
      return r;
   endfunction

   logic [WIDTH-1:0]      count_r;
   logic [PRESCALE_W-1:0] div_r;
   logic                  tc_r;
   logic                  ovf_r;

   logic [WIDTH-1:0]      count_nxt_s;
   logic [PRESCALE_W-1:0] div_nxt_s;
   logic                  tc_nxt_s;
   logic                  ovf_nxt_s;
   logic                  div_match_s;
   step_t                 step_res_s;

   // Next-state selection: clear beats load beats a prescaled step.
   always_comb begin
      count_nxt_s = count_r;
      div_nxt_s   = div_r;
      tc_nxt_s    = 1'b0;
      ovf_nxt_s   = ovf_r;

      // A divider left above a freshly lowered prescale is treated as a match.
      div_match_s = (div_r >= prescale);

      if (dir) begin
         step_res_s = step_up(count_r, max_value);
      end else begin
         step_res_s = step_down(count_r, max_value);
      end

      if (clear) begin
         count_nxt_s = RESET_VALUE;
         div_nxt_s   = DIV_ZERO_C;
      end else if (load) begin
         count_nxt_s = load_value;
         div_nxt_s   = DIV_ZERO_C;
      end else if (en) begin
         if (div_match_s) begin
            div_nxt_s   = DIV_ZERO_C;
            count_nxt_s = step_res_s.value;
            tc_nxt_s    = step_res_s.hit;
         end else begin
            div_nxt_s   = div_r + DIV_ONE_C;
         end
      end else begin
         count_nxt_s = count_r;
         div_nxt_s   = div_r;
      end

      // A new terminal count wins over a simultaneous clear request.
      if (tc_nxt_s) begin
         ovf_nxt_s = 1'b1;
      end else if (ovf_clr) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
   end

   // State registers; reset forces the idle state without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= RESET_VALUE;
         div_r   <= DIV_ZERO_C;
         tc_r    <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         div_r   <= div_nxt_s;
         tc_r    <= tc_nxt_s;
         ovf_r   <= ovf_nxt_s;
      end
   end

   assign count      = count_r;
   assign tc         = tc_r;
   assign ovf_sticky = ovf_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: a wrapping instance (RESET_VALUE=0) and a
// saturating instance (RESET_VALUE=3) share one set of inputs.

module tb_counter_ctrl;

   logic       clk;
   logic       reset;
   logic       en;
   logic       clear;
   logic       load;
   logic [7:0] load_value;
   logic       dir;
   logic [7:0] max_value;
   logic [3:0] prescale;
   logic       ovf_clr;

   logic [7:0] count_w, count_s;
   logic       tc_w, tc_s, ovf_w, ovf_s;

   int n_total;
   int n_pass;

   counter_ctrl #(.WIDTH(8), .PRESCALE_W(4), .RESET_VALUE(8'd0), .SATURATE(1'b0)) dut_w (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
      .load_value(load_value), .dir(dir), .max_value(max_value),
      .prescale(prescale), .ovf_clr(ovf_clr),
      .count(count_w), .tc(tc_w), .ovf_sticky(ovf_w));

   counter_ctrl #(.WIDTH(8), .PRESCALE_W(4), .RESET_VALUE(8'd3), .SATURATE(1'b1)) dut_s (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
      .load_value(load_value), .dir(dir), .max_value(max_value),
      .prescale(prescale), .ovf_clr(ovf_clr),
      .count(count_s), .tc(tc_s), .ovf_sticky(ovf_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       clr;
      logic       ld;
      logic [7:0] ldv;
      logic       dir;
      logic [7:0] maxv;
      logic [3:0] pre;
      logic       oclr;
      int         ecnt;
      int         etc;
      int         eovf;
   } vec_t;

   vec_t vecs [0:18];

   // Saturate/wrap step sequence: dir, max, then expected (count, tc) per instance.
   int sq_dir [0:8] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
   int sq_max [0:8] = '{9, 9, 9, 9, 9, 9, 9, 3, 3};
   int sq_cs  [0:8] = '{1, 0, 0, 0, 1, 2, 3, 3, 3};
   int sq_ts  [0:8] = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
   int sq_cw  [0:8] = '{1, 0, 9, 8, 9, 0, 1, 2, 3};
   int sq_tw  [0:8] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};

   function automatic vec_t mk(input logic e, input logic c, input logic l, input int ldv,
                               input logic d, input int mx, input int pr, input logic oc,
                               input int ecnt, input int etc, input int eovf);
      vec_t v;
      v.en = e; v.clr = c; v.ld = l; v.ldv = 8'(ldv); v.dir = d;
      v.maxv = 8'(mx); v.pre = 4'(pr); v.oclr = oc;
      v.ecnt = ecnt; v.etc = etc; v.eovf = eovf;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count_w"}, int'(count_w), 0);
      chk({tag, "_tc_w"}, int'(tc_w), 0);
      chk({tag, "_ovf_w"}, int'(ovf_w), 0);
      chk({tag, "_count_s"}, int'(count_s), 3);
   endtask

   initial begin
      int m;
      int pulses;
      n_total = 0;
      n_pass  = 0;

      vecs[0]  = mk(1, 1, 1, 77,  1, 50,  0, 1, 0,  0, 0);
      vecs[1]  = mk(0, 0, 1, 200, 1, 50,  0, 0, 200, 0, 0);
      vecs[2]  = mk(1, 0, 0, 0,   1, 50,  0, 0, 0,  1, 1);
      vecs[3]  = mk(0, 0, 1, 200, 1, 50,  0, 0, 200, 0, 1);
      vecs[4]  = mk(1, 0, 0, 0,   0, 50,  0, 0, 50, 0, 1);
      vecs[5]  = mk(1, 0, 0, 0,   0, 50,  0, 1, 49, 0, 0);
      vecs[6]  = mk(0, 0, 1, 1,   0, 50,  0, 0, 1,  0, 0);
      vecs[7]  = mk(1, 0, 0, 0,   0, 50,  0, 0, 0,  0, 0);
      vecs[8]  = mk(1, 0, 0, 0,   0, 50,  0, 1, 50, 1, 1);
      vecs[9]  = mk(0, 0, 0, 0,   0, 50,  0, 1, 50, 0, 0);
      vecs[10] = mk(1, 0, 0, 0,   1, 0,   0, 0, 0,  1, 1);
      vecs[11] = mk(1, 0, 0, 0,   1, 0,   0, 0, 0,  1, 1);
      vecs[12] = mk(1, 0, 0, 0,   0, 0,   0, 1, 0,  1, 1);
      vecs[13] = mk(1, 0, 0, 0,   1, 255, 2, 1, 0,  0, 0);
      vecs[14] = mk(1, 0, 0, 0,   1, 255, 2, 0, 0,  0, 0);
      vecs[15] = mk(1, 0, 0, 0,   1, 255, 0, 0, 1,  0, 0);
      vecs[16] = mk(1, 0, 0, 0,   1, 255, 3, 0, 1,  0, 0);
      vecs[17] = mk(1, 0, 0, 0,   1, 255, 3, 0, 1,  0, 0);
      vecs[18] = mk(1, 0, 0, 0,   1, 255, 1, 0, 2,  0, 0);

      reset = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; load_value = 8'd0;
      dir = 1'b1; max_value = 8'd255; prescale = 4'd0; ovf_clr = 1'b0;

      // Reset state, both before and across a clock edge.
      #2;
      chk_reset_state("rst");
      en = 1'b1;
      tick();
      chk_reset_state("rst_hold");
      reset = 1'b0;

      // Free-running binary count through the natural wrap.
      for (int k = 1; k <= 300; k++) begin
         tick();
         chk("free_count", int'(count_w), k % 256);
         chk("free_tc", int'(tc_w), (k == 256) ? 1 : 0);
      end
      chk("free_ovf", int'(ovf_w), 1);

      // Prescale 3, limit 9, with a 5-cycle enable gap mid-run.
      clear = 1'b1; ovf_clr = 1'b1;
      tick();
      chk("clr_count", int'(count_w), 0);
      chk("clr_ovf", int'(ovf_w), 0);
      clear = 1'b0; ovf_clr = 1'b0; prescale = 4'd3; max_value = 8'd9; dir = 1'b1;
      m = 0;
      pulses = 0;
      for (int i = 0; i < 45; i++) begin
         en = (i >= 18 && i < 23) ? 1'b0 : 1'b1;
         tick();
         if (en) m++;
         chk("pre_count", int'(count_w), (m / 4) % 10);
         chk("pre_tc", int'(tc_w),
             (en && m > 0 && (m % 4) == 0 && ((m / 4) % 10) == 0) ? 1 : 0);
         if (tc_w) pulses++;
      end
      chk("pre_final_count", int'(count_w), 0);
      chk("pre_tc_pulses", pulses, 1);

      // Load 2, then count down into the bounds and back up.
      en = 1'b0; load = 1'b1; load_value = 8'd2; dir = 1'b0; prescale = 4'd0; max_value = 8'd9;
      tick();
      chk("sq_load_s", int'(count_s), 2);
      chk("sq_load_w", int'(count_w), 2);
      chk("sq_load_tc_s", int'(tc_s), 0);
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         dir = (sq_dir[i] != 0);
         max_value = 8'(sq_max[i]);
         tick();
         chk("sq_count_s", int'(count_s), sq_cs[i]);
         chk("sq_tc_s", int'(tc_s), sq_ts[i]);
         chk("sq_count_w", int'(count_w), sq_cw[i]);
         chk("sq_tc_w", int'(tc_w), sq_tw[i]);
      end
      chk("sq_ovf_s", int'(ovf_s), 1);

      // Clear, load and step requested together: clear wins.
      clear = 1'b1; load = 1'b1; load_value = 8'd77;
      tick();
      chk("cls_count_s", int'(count_s), 3);
      chk("cls_tc_s", int'(tc_s), 0);
      chk("cls_count_w", int'(count_w), 0);
      clear = 1'b0; load = 1'b0;

      // Table of priority, out-of-range load, ovf and prescale-change cases.
      for (int i = 0; i <= 18; i++) begin
         en = vecs[i].en; clear = vecs[i].clr; load = vecs[i].ld;
         load_value = vecs[i].ldv; dir = vecs[i].dir; max_value = vecs[i].maxv;
         prescale = vecs[i].pre; ovf_clr = vecs[i].oclr;
         tick();
         chk($sformatf("vec%0d_count", i), int'(count_w), vecs[i].ecnt);
         chk($sformatf("vec%0d_tc", i), int'(tc_w), vecs[i].etc);
         chk($sformatf("vec%0d_ovf", i), int'(ovf_w), vecs[i].eovf);
      end
      clear = 1'b0; load = 1'b0; ovf_clr = 1'b0;

      // Asynchronous reset mid-count (count=7, div=2), then restart.
      en = 1'b0; load = 1'b1; load_value = 8'd7;
      tick();
      load = 1'b0; en = 1'b1; prescale = 4'd5; dir = 1'b1; max_value = 8'd255;
      tick();
      tick();
      chk("arst_pre_count", int'(count_w), 7);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_state("arst");
      tick();
      reset = 1'b0; prescale = 4'd2;
      tick();
      chk("arst_e1_count", int'(count_w), 0);
      tick();
      chk("arst_e2_count", int'(count_w), 0);
      tick();
      chk("arst_e3_count", int'(count_w), 1);
      chk("arst_e3_tc", int'(tc_w), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
